// File: rtl/vga_text_buffer.sv
// Text-mode character/attribute buffer. It holds the cursor, a circular row offset
// for scrolling and a blank-fill sequencer, and serves a 2-cycle scan-out read port.
module vga_text_buffer #(
  parameter int          H_DISP    = 1280,
  parameter int          V_DISP    = 1024,
  parameter int          FONT_W    = 8,
  parameter int          FONT_H    = 8,
  parameter int          ATTR_W    = 8,
  parameter bit          SCROLL_EN = 1'b1,
  parameter logic [31:0] BLANK     = 32'h0000_0720,
  localparam int         COLS      = H_DISP / FONT_W,
  localparam int         ROWS      = V_DISP / FONT_H,
  localparam int         DW        = 8 + ATTR_W,
  localparam int         XW        = $clog2(COLS),
  localparam int         YW        = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [DW-1:0] cmd_data,
  input  logic [XW-1:0] rd_col,
  input  logic [YW-1:0] rd_row,
  output logic [DW-1:0] rd_data,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic          busy
);

  localparam int             DEPTH   = ROWS * COLS;
  localparam int             AW      = $clog2(DEPTH);
  localparam int             YW1     = YW + 1;
  localparam logic [XW-1:0]  X_MAX   = XW'(COLS - 1);
  localparam logic [YW-1:0]  Y_MAX   = YW'(ROWS - 1);
  localparam logic [YW1-1:0] ROWS_W  = YW1'(ROWS);
  localparam logic [AW-1:0]  COLS_A  = AW'(COLS);
  localparam logic [AW-1:0]  LAST_A  = AW'(DEPTH - 1);
  localparam logic [DW-1:0]  BLANK_C = DW'(BLANK);

  typedef enum logic [1:0] {S_IDLE, S_CLR_ALL, S_CLR_ROW} state_e;
  typedef enum logic [2:0] {
    OP_NOP, OP_UP, OP_DOWN, OP_LEFT, OP_RIGHT, OP_NEWLINE, OP_WRITE, OP_CLEAR
  } op_e;

  // Logical-to-physical row rotation: compare-and-subtract instead of a divider.
  function automatic logic [YW-1:0] phys_row(input logic [YW-1:0] lrow,
                                             input logic [YW-1:0] top);
    logic [YW1-1:0] sum;
    sum = {1'b0, lrow} + {1'b0, top};
    if (sum >= ROWS_W) sum = sum - ROWS_W;
    return sum[YW-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] prow,
                                              input logic [XW-1:0] col);
    return AW'(prow) * COLS_A + AW'(col);
  endfunction

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [YW-1:0] top_q, top_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [AW-1:0] clr_last_q, clr_last_d;
  logic [AW-1:0] rd_addr_q;
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] mem [DEPTH];

  logic          line_feed;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;

  assign busy      = (state_q != S_IDLE);
  assign cmd_ready = !busy;
  assign cursor_x  = x_q;
  assign cursor_y  = y_q;
  assign rd_data   = rd_data_q;

  // NOTE: every signal gets a default before any branch, so no path can leave a latch.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    top_d      = top_q;
    clr_addr_d = clr_addr_q;
    clr_last_d = clr_last_q;
    line_feed  = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = clr_addr_q;
    ram_wdata  = BLANK_C;

    if (state_q != S_IDLE) begin
      ram_we     = 1'b1;
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == clr_last_q) state_d = S_IDLE;
    end else if (cmd_valid) begin
      case (cmd_op)
        OP_UP:      if (y_q != '0)    y_d = y_q - 1'b1;
        OP_DOWN:    if (y_q != Y_MAX) y_d = y_q + 1'b1;
        OP_LEFT:    if (x_q != '0)    x_d = x_q - 1'b1;
        OP_RIGHT:   if (x_q != X_MAX) x_d = x_q + 1'b1;
        OP_NEWLINE: begin
          x_d       = '0;
          line_feed = 1'b1;
        end
        OP_WRITE: begin
          ram_we    = 1'b1;
          ram_waddr = cell_addr(phys_row(y_q, top_q), x_q);
          ram_wdata = cmd_data;
          if (x_q == X_MAX) begin
            x_d       = '0;
            line_feed = 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
        OP_CLEAR: begin
          x_d        = '0;
          y_d        = '0;
          top_d      = '0;
          state_d    = S_CLR_ALL;
          clr_addr_d = '0;
          clr_last_d = LAST_A;
        end
        default: ;
      endcase

      if (line_feed) begin
        if (y_q != Y_MAX) begin
          y_d = y_q + 1'b1;
        end else if (SCROLL_EN) begin
          // The old top physical row becomes the new bottom line and is blanked.
          top_d      = (top_q == Y_MAX) ? '0 : top_q + 1'b1;
          state_d    = S_CLR_ROW;
          clr_addr_d = cell_addr(top_q, '0);
          clr_last_d = cell_addr(top_q, X_MAX);
        end else begin
          y_d = '0;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_CLR_ALL;
      x_q        <= '0;
      y_q        <= '0;
      top_q      <= '0;
      clr_addr_q <= '0;
      clr_last_q <= LAST_A;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      top_q      <= top_d;
      clr_addr_q <= clr_addr_d;
      clr_last_q <= clr_last_d;
      rd_addr_q  <= cell_addr(phys_row(rd_row, top_q), rd_col);
      rd_data_q  <= mem[rd_addr_q];
    end
  end

  // NOTE: the cell array has no reset so it maps onto block RAM; the clear sequencer fills it.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

endmodule

// File: tb/tb_vga_text_buffer.sv
// Bench for vga_text_buffer on a 4x4 grid: one instance scrolls, one wraps.
// Read expectations go through a queue that a monitor drains as read data emerges.
module tb_vga_text_buffer;

  localparam logic [2:0] OP_NOP = 3'd0, OP_UP = 3'd1, OP_DOWN = 3'd2, OP_LEFT = 3'd3,
                         OP_RIGHT = 3'd4, OP_NEWLINE = 3'd5, OP_WRITE = 3'd6,
                         OP_CLEAR = 3'd7;
  localparam logic [15:0] BLANK = 16'h0720;

  typedef struct {
    int          dut;
    string       name;
    logic [15:0] exp;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [2:0]  cmd_op    [2];
  logic [15:0] cmd_data  [2];
  logic [15:0] rd_data   [2];
  logic [1:0]  cursor_x  [2];
  logic [1:0]  cursor_y  [2];
  logic        busy      [2];
  logic [1:0]  rd_row, rd_col;
  logic        rd_en;

  int      checks = 0;
  int      errors = 0;
  rd_exp_t exp_q[$];
  rd_exp_t e;
  bit      v1 = 1'b0, v2 = 1'b0;
  int      n;

  always #5 clk = ~clk;

  vga_text_buffer #(.H_DISP(32), .V_DISP(32), .SCROLL_EN(1'b1)) u_scroll (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
    .cmd_data(cmd_data[0]), .rd_col(rd_col), .rd_row(rd_row), .rd_data(rd_data[0]),
    .cursor_x(cursor_x[0]), .cursor_y(cursor_y[0]), .busy(busy[0])
  );

  vga_text_buffer #(.H_DISP(32), .V_DISP(32), .SCROLL_EN(1'b0)) u_wrap (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
    .cmd_data(cmd_data[1]), .rd_col(rd_col), .rd_row(rd_row), .rd_data(rd_data[1]),
    .cursor_x(cursor_x[1]), .cursor_y(cursor_y[1]), .busy(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_cursor(input int d, input string name, input int x, input int y);
    check({name, " x"}, 32'(cursor_x[d]), 32'(x));
    check({name, " y"}, 32'(cursor_y[d]), 32'(y));
  endtask

  task automatic do_cmd(input int d, input logic [2:0] op, input logic [15:0] data);
    @(negedge clk);
    check("cmd_ready idle", 32'(cmd_ready[d]), 32'd1);
    cmd_valid[d] = 1'b1;
    cmd_op[d]    = op;
    cmd_data[d]  = data;
    @(negedge clk);
    cmd_valid[d] = 1'b0;
    cmd_op[d]    = OP_NOP;
  endtask

  task automatic do_read(input int d, input int r, input int c, input logic [15:0] exp,
                         input string nm);
    @(negedge clk);
    rd_row = 2'(r);
    rd_col = 2'(c);
    rd_en  = 1'b1;
    exp_q.push_back('{d, $sformatf("%s r%0d c%0d", nm, r, c), exp});
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Counts cycles with busy high, starting from the current sample point.
  task automatic count_busy(input int d, output int cnt);
    cnt = 0;
    while (busy[d] && cnt < 100) begin
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  // Read data appears two rising edges after the request was sampled.
  always @(posedge clk) begin
    v2 = v1;
    v1 = rd_en;
    #1;
    if (v2) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd unexpected: got data with no pending request");
      end else begin
        e = exp_q.pop_front();
        check(e.name, 32'(rd_data[e.dut]), 32'(e.exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    reset  = 1'b0;
    rd_en  = 1'b0;
    rd_row = '0;
    rd_col = '0;
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0;
      cmd_op[d]    = OP_NOP;
      cmd_data[d]  = '0;
    end

    // Reset state and power-up clear.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_cursor(d, "reset cursor", 0, 0);
      check("reset rd_data", 32'(rd_data[d]), 32'd0);
    end
    reset = 1'b1;
    check("busy after release", 32'(busy[0]), 32'd1);
    check("cmd_ready after release", 32'(cmd_ready[0]), 32'd0);
    count_busy(0, n);
    check("power-up clear cycles", 32'(n), 32'd16);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        do_read(0, r, c, BLANK, "blank after reset");

    // Write with auto-advance.
    do_cmd(0, OP_WRITE, 16'h1F41);
    check_cursor(0, "after write", 1, 0);
    do_read(0, 0, 0, 16'h1F41, "written cell");

    // Clamped cursor moves.
    do_cmd(0, OP_LEFT, '0);
    do_cmd(0, OP_LEFT, '0);
    check_cursor(0, "left clamp", 0, 0);
    repeat (4) do_cmd(0, OP_RIGHT, '0);
    check_cursor(0, "right clamp", 3, 0);
    do_cmd(0, OP_UP, '0);
    check_cursor(0, "up clamp", 3, 0);
    repeat (5) do_cmd(0, OP_DOWN, '0);
    check_cursor(0, "down clamp", 3, 3);

    // Write in the last cell scrolls the screen and blanks the new bottom line.
    do_cmd(0, OP_WRITE, 16'h0042);
    check_cursor(0, "after scroll", 0, 3);
    count_busy(0, n);
    check("row clear cycles", 32'(n), 32'd4);
    for (int c = 0; c < 4; c++) do_read(0, 3, c, BLANK, "new bottom line");
    do_read(0, 2, 3, 16'h0042, "scrolled cell");
    do_read(0, 0, 0, BLANK, "old row 1");

    // Without scrolling, a newline on the last row wraps to the top.
    do_cmd(1, OP_WRITE, 16'h0A33);
    do_cmd(1, OP_RIGHT, '0);
    repeat (3) do_cmd(1, OP_DOWN, '0);
    check_cursor(1, "wrap setup", 2, 3);
    do_cmd(1, OP_NEWLINE, '0);
    check_cursor(1, "newline wrap", 0, 0);
    check("wrap busy", 32'(busy[1]), 32'd0);
    @(negedge clk);
    check("wrap busy later", 32'(busy[1]), 32'd0);
    do_read(1, 0, 0, 16'h0A33, "wrap kept cell");
    do_read(1, 3, 2, BLANK, "wrap blank cell");

    // CLEAR with a WRITE held during busy: dropped until the clear finishes.
    @(negedge clk);
    cmd_valid[0] = 1'b1;
    cmd_op[0]    = OP_CLEAR;
    @(negedge clk);
    check("clear busy", 32'(busy[0]), 32'd1);
    check("clear cmd_ready", 32'(cmd_ready[0]), 32'd0);
    cmd_op[0]   = OP_WRITE;
    cmd_data[0] = 16'hBEEF;
    count_busy(0, n);
    check("clear-all cycles", 32'(n), 32'd16);
    @(negedge clk);
    check_cursor(0, "after clear", 0, 0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    cmd_op[0]    = OP_NOP;
    check_cursor(0, "write after clear", 1, 0);
    do_read(0, 0, 0, 16'hBEEF, "post-clear write");
    do_read(0, 0, 1, BLANK, "cleared cell");
    do_read(0, 2, 3, BLANK, "cleared old data");
    do_read(0, 3, 3, BLANK, "cleared last cell");

    repeat (4) @(negedge clk);
    check("pending reads", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
